chess_board_state: RTL and testbench

- Clocked, parametrised board-state matrix for the chess datapath.
- Holds one SQUARE_WIDTH piece code per square and loads the standard layout on reset.
- Runs a cursor/select/move state machine driven by the push-button keys.
- Publishes the packed Matrix to the renderer, plus cursor, selection, turn and move-event status for the timer logic.

---
 rtl/chess_board_state.sv | 242 ++++++++++++++++++++++++
 tb/tb_chess_board_state.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_board_state.sv
// Board-state matrix with push-button cursor/select/move FSM for the chess datapath.
// Define CHESS_UNDO_EN to build the single-level move undo history.
module chess_board_state #(
  parameter int BOARD_DIM     = 8,
  parameter int SQUARE_WIDTH  = 4,
  parameter int CHESS_SQUARES = BOARD_DIM * BOARD_DIM,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH,
  parameter int COORD_WIDTH   = $clog2(BOARD_DIM),
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    resetApp,
  input  logic                    KeyLeft,
  input  logic                    KeyRight,
  input  logic                    KeyUp,
  input  logic                    KeyDown,
  input  logic                    KeySelect,
  input  logic                    KeyUndo,
  output logic [MATRIX_WIDTH-1:0] Matrix,
  output logic [COORD_WIDTH-1:0]  CursorRow,
  output logic [COORD_WIDTH-1:0]  CursorCol,
  output logic [COORD_WIDTH-1:0]  SelRow,
  output logic [COORD_WIDTH-1:0]  SelCol,
  output logic                    PieceSelected,
  output logic                    Turn,
  output logic                    MoveDone,
  output logic [SQUARE_WIDTH-1:0] CapturedPiece,
  output logic [COUNT_WIDTH-1:0]  MoveCount
);

  localparam int IDX_WIDTH = 2 * COORD_WIDTH;
  localparam int K_SEL   = 5;
  localparam int K_UNDO  = 4;
  localparam int K_UP    = 3;
  localparam int K_DOWN  = 2;
  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 0;

  typedef enum logic {S_IDLE = 1'b0, S_SELECTED = 1'b1} state_t;

  function automatic logic [MATRIX_WIDTH-1:0] reset_layout();
    logic [MATRIX_WIDTH-1:0] m;
    logic [2:0]              back;
    m = '0;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0, 7:    back = 3'd4;
        1, 6:    back = 3'd2;
        2, 5:    back = 3'd3;
        3:       back = 3'd5;
        4:       back = 3'd6;
        default: back = 3'd0;
      endcase
      m[c*SQUARE_WIDTH +: SQUARE_WIDTH] = SQUARE_WIDTH'({1'b0, back});
      m[((BOARD_DIM-1)*BOARD_DIM + c)*SQUARE_WIDTH +: SQUARE_WIDTH] = SQUARE_WIDTH'({1'b1, back});
    end
    for (int c = 0; c < BOARD_DIM; c++) begin
      m[(BOARD_DIM + c)*SQUARE_WIDTH +: SQUARE_WIDTH] = SQUARE_WIDTH'(4'd1);
      m[((BOARD_DIM-2)*BOARD_DIM + c)*SQUARE_WIDTH +: SQUARE_WIDTH] = SQUARE_WIDTH'(4'd9);
    end
    return m;
  endfunction

  localparam logic [MATRIX_WIDTH-1:0] INIT_MATRIX = reset_layout();

  state_t                  r_state, w_state_nxt;
  logic [MATRIX_WIDTH-1:0] r_matrix, w_matrix_nxt;
  logic [5:0]              r_keys_prev, w_keys, w_edge;
  logic [COORD_WIDTH-1:0]  r_cur_row, r_cur_col, r_sel_row, r_sel_col;
  logic [COORD_WIDTH-1:0]  w_cur_row_nxt, w_cur_col_nxt, w_sel_row_nxt, w_sel_col_nxt;
  logic                    r_turn, w_turn_nxt, r_move_done, w_move_done_nxt;
  logic [SQUARE_WIDTH-1:0] r_captured, w_captured_nxt;
  logic [COUNT_WIDTH-1:0]  r_count, w_count_nxt;
  logic [IDX_WIDTH-1:0]    w_cur_idx, w_sel_idx;
  logic [SQUARE_WIDTH-1:0] w_cur_code, w_sel_code;
  logic                    w_cur_own;

`ifdef CHESS_UNDO_EN
  logic                    r_undo_valid, w_undo_valid_nxt;
  logic [IDX_WIDTH-1:0]    r_undo_src, r_undo_dst, w_undo_src_nxt, w_undo_dst_nxt;
  logic [SQUARE_WIDTH-1:0] r_undo_moved, r_undo_capt, w_undo_moved_nxt, w_undo_capt_nxt;
`endif

  assign w_keys     = {KeySelect, KeyUndo, KeyUp, KeyDown, KeyLeft, KeyRight};
  assign w_edge     = w_keys & ~r_keys_prev;
  assign w_cur_idx  = {r_cur_row, r_cur_col};
  assign w_sel_idx  = {r_sel_row, r_sel_col};
  assign w_cur_code = r_matrix[int'(w_cur_idx)*SQUARE_WIDTH +: SQUARE_WIDTH];
  assign w_sel_code = r_matrix[int'(w_sel_idx)*SQUARE_WIDTH +: SQUARE_WIDTH];
  assign w_cur_own  = (w_cur_code[2:0] != 3'd0) && (w_cur_code[3] == r_turn);

  // Next-state: one prioritised key action per cycle drives FSM, cursor and board.
  always_comb begin
    w_state_nxt     = r_state;
    w_matrix_nxt    = r_matrix;
    w_cur_row_nxt   = r_cur_row;
    w_cur_col_nxt   = r_cur_col;
    w_sel_row_nxt   = r_sel_row;
    w_sel_col_nxt   = r_sel_col;
    w_turn_nxt      = r_turn;
    w_move_done_nxt = 1'b0;
    w_captured_nxt  = r_captured;
    w_count_nxt     = r_count;
`ifdef CHESS_UNDO_EN
    w_undo_valid_nxt = r_undo_valid;
    w_undo_src_nxt   = r_undo_src;
    w_undo_dst_nxt   = r_undo_dst;
    w_undo_moved_nxt = r_undo_moved;
    w_undo_capt_nxt  = r_undo_capt;
`endif
    if (w_edge[K_SEL]) begin
      case (r_state)
        S_IDLE: begin
          if (w_cur_own) begin
            w_sel_row_nxt = r_cur_row;
            w_sel_col_nxt = r_cur_col;
            w_state_nxt   = S_SELECTED;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_SELECTED: begin
          if (w_cur_idx == w_sel_idx) begin
            w_state_nxt = S_IDLE;
          end else if (w_cur_own) begin
            w_sel_row_nxt = r_cur_row;
            w_sel_col_nxt = r_cur_col;
          end else begin
            w_matrix_nxt[int'(w_cur_idx)*SQUARE_WIDTH +: SQUARE_WIDTH] = w_sel_code;
            w_matrix_nxt[int'(w_sel_idx)*SQUARE_WIDTH +: SQUARE_WIDTH] = '0;
            w_captured_nxt  = w_cur_code;
            w_turn_nxt      = ~r_turn;
            w_count_nxt     = r_count + COUNT_WIDTH'(1);
            w_move_done_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
`ifdef CHESS_UNDO_EN
            w_undo_valid_nxt = 1'b1;
            w_undo_src_nxt   = w_sel_idx;
            w_undo_dst_nxt   = w_cur_idx;
            w_undo_moved_nxt = w_sel_code;
            w_undo_capt_nxt  = w_cur_code;
`endif
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_edge[K_UNDO]) begin
`ifdef CHESS_UNDO_EN
      if ((r_state == S_IDLE) && r_undo_valid) begin
        w_matrix_nxt[int'(r_undo_src)*SQUARE_WIDTH +: SQUARE_WIDTH] = r_undo_moved;
        w_matrix_nxt[int'(r_undo_dst)*SQUARE_WIDTH +: SQUARE_WIDTH] = r_undo_capt;
        w_turn_nxt       = ~r_turn;
        w_count_nxt      = r_count - COUNT_WIDTH'(1);
        w_captured_nxt   = '0;
        w_undo_valid_nxt = 1'b0;
      end else begin
        w_undo_valid_nxt = r_undo_valid;
      end
`else
      // Undo still wins arbitration so lower-priority edges this cycle are dropped.
      w_state_nxt = r_state;
`endif
    end else if (w_edge[K_UP]) begin
      w_cur_row_nxt = r_cur_row + COORD_WIDTH'(1);
    end else if (w_edge[K_DOWN]) begin
      w_cur_row_nxt = r_cur_row - COORD_WIDTH'(1);
    end else if (w_edge[K_LEFT]) begin
      w_cur_col_nxt = r_cur_col - COORD_WIDTH'(1);
    end else if (w_edge[K_RIGHT]) begin
      w_cur_col_nxt = r_cur_col + COORD_WIDTH'(1);
    end else begin
      w_cur_row_nxt = r_cur_row;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Board, cursor, selection and status registers.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_matrix    <= INIT_MATRIX;
      r_keys_prev <= '0;
      r_cur_row   <= '0;
      r_cur_col   <= '0;
      r_sel_row   <= '0;
      r_sel_col   <= '0;
      r_turn      <= 1'b0;
      r_move_done <= 1'b0;
      r_captured  <= '0;
      r_count     <= '0;
    end else begin
      r_matrix    <= w_matrix_nxt;
      r_keys_prev <= w_keys;
      r_cur_row   <= w_cur_row_nxt;
      r_cur_col   <= w_cur_col_nxt;
      r_sel_row   <= w_sel_row_nxt;
      r_sel_col   <= w_sel_col_nxt;
      r_turn      <= w_turn_nxt;
      r_move_done <= w_move_done_nxt;
      r_captured  <= w_captured_nxt;
      r_count     <= w_count_nxt;
    end
  end

`ifdef CHESS_UNDO_EN
  // Single-level undo history.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_undo_valid <= 1'b0;
      r_undo_src   <= '0;
      r_undo_dst   <= '0;
      r_undo_moved <= '0;
      r_undo_capt  <= '0;
    end else begin
      r_undo_valid <= w_undo_valid_nxt;
      r_undo_src   <= w_undo_src_nxt;
      r_undo_dst   <= w_undo_dst_nxt;
      r_undo_moved <= w_undo_moved_nxt;
      r_undo_capt  <= w_undo_capt_nxt;
    end
  end
`endif

  assign Matrix        = r_matrix;
  assign CursorRow     = r_cur_row;
  assign CursorCol     = r_cur_col;
  assign SelRow        = r_sel_row;
  assign SelCol        = r_sel_col;
  assign PieceSelected = (r_state == S_SELECTED);
  assign Turn          = r_turn;
  assign MoveDone      = r_move_done;
  assign CapturedPiece = r_captured;
  assign MoveCount     = r_count;

endmodule

// File: tb/tb_chess_board_state.sv
// Scoreboard bench for chess_board_state: stimulus queues expectations, a negedge monitor checks them.
module tb_chess_board_state;

  localparam int SW = 4;
  localparam int K_SQ = 0, K_CROW = 1, K_CCOL = 2, K_SROW = 3, K_SCOL = 4;
  localparam int K_PSEL = 5, K_TURN = 6, K_MD = 7, K_CAP = 8, K_MC = 9;
  localparam int KEY_SEL = 0, KEY_UNDO = 1, KEY_UP = 2, KEY_DN = 3, KEY_LF = 4, KEY_RT = 5;

  logic         clock = 1'b0;
  logic         resetApp = 1'b1;
  logic         KeyLeft = 1'b0, KeyRight = 1'b0, KeyUp = 1'b0, KeyDown = 1'b0;
  logic         KeySelect = 1'b0, KeyUndo = 1'b0;
  logic [255:0] Matrix;
  logic [2:0]   CursorRow, CursorCol, SelRow, SelCol;
  logic         PieceSelected, Turn, MoveDone;
  logic [3:0]   CapturedPiece;
  logic [7:0]   MoveCount;

  typedef struct {
    string name;
    int    kind;
    int    idx;
    int    exp;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  chess_board_state dut (
    .clock(clock), .resetApp(resetApp),
    .KeyLeft(KeyLeft), .KeyRight(KeyRight), .KeyUp(KeyUp), .KeyDown(KeyDown),
    .KeySelect(KeySelect), .KeyUndo(KeyUndo),
    .Matrix(Matrix), .CursorRow(CursorRow), .CursorCol(CursorCol),
    .SelRow(SelRow), .SelCol(SelCol), .PieceSelected(PieceSelected),
    .Turn(Turn), .MoveDone(MoveDone), .CapturedPiece(CapturedPiece), .MoveCount(MoveCount)
  );

  always #5 clock = ~clock;

  function automatic int layout(int idx);
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int row = idx / 8;
    int col = idx % 8;
    if (row == 0) return back[col];
    if (row == 7) return back[col] + 8;
    if (row == 1) return 1;
    if (row == 6) return 9;
    return 0;
  endfunction

  function automatic int actual(int kind, int idx);
    case (kind)
      K_SQ:    return int'(Matrix[idx*SW +: SW]);
      K_CROW:  return int'(CursorRow);
      K_CCOL:  return int'(CursorCol);
      K_SROW:  return int'(SelRow);
      K_SCOL:  return int'(SelCol);
      K_PSEL:  return int'(PieceSelected);
      K_TURN:  return int'(Turn);
      K_MD:    return int'(MoveDone);
      K_CAP:   return int'(CapturedPiece);
      K_MC:    return int'(MoveCount);
      default: return -1;
    endcase
  endfunction

  task automatic expect_v(string name, int kind, int idx, int exp);
    exp_t e;
    e.name = name; e.kind = kind; e.idx = idx; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic expect_sq(string name, int idx, int exp);
    expect_v($sformatf("%s sq%0d", name, idx), K_SQ, idx, exp);
  endtask

  task automatic expect_status(string name, int psel, int turn, int mc, int cap);
    expect_v({name, " psel"}, K_PSEL, 0, psel);
    expect_v({name, " turn"}, K_TURN, 0, turn);
    expect_v({name, " count"}, K_MC, 0, mc);
    expect_v({name, " captured"}, K_CAP, 0, cap);
  endtask

  task automatic expect_reset(string name);
    for (int i = 0; i < 64; i++) expect_sq(name, i, layout(i));
    expect_status(name, 0, 0, 0, 0);
    expect_v({name, " crow"}, K_CROW, 0, 0);
    expect_v({name, " ccol"}, K_CCOL, 0, 0);
    expect_v({name, " srow"}, K_SROW, 0, 0);
    expect_v({name, " scol"}, K_SCOL, 0, 0);
    expect_v({name, " movedone"}, K_MD, 0, 0);
  endtask

  // Monitor: DUT state is settled at the falling edge; check everything queued so far.
  always @(negedge clock) begin
    exp_t e;
    int   a;
    while (q.size() > 0) begin
      e = q.pop_front();
      a = actual(e.kind, e.idx);
      n_total++;
      if (a == e.exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", e.name, a, e.exp);
    end
  end

  task automatic set_key(int k, logic v);
    case (k)
      KEY_SEL:  KeySelect = v;
      KEY_UNDO: KeyUndo   = v;
      KEY_UP:   KeyUp     = v;
      KEY_DN:   KeyDown   = v;
      KEY_LF:   KeyLeft   = v;
      KEY_RT:   KeyRight  = v;
      default:  ;
    endcase
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // One clean press: a low cycle first so the edge detector re-arms, then one high cycle.
  task automatic act(int k);
    tick();
    set_key(k, 1'b1);
    tick();
    set_key(k, 1'b0);
  endtask

  task automatic moves(int k, int n);
    repeat (n) act(k);
  endtask

  task automatic expect_cursor(string name, int r, int c);
    expect_v({name, " crow"}, K_CROW, 0, r);
    expect_v({name, " ccol"}, K_CCOL, 0, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 resetApp = 1'b0;
    expect_reset("reset");

    // Select and Left rise together: only select happens.
    tick();
    KeySelect = 1'b1; KeyLeft = 1'b1;
    tick();
    KeySelect = 1'b0; KeyLeft = 1'b0;
    expect_v("simul psel", K_PSEL, 0, 1);
    expect_cursor("simul", 0, 0);
    act(KEY_SEL);
    expect_v("cancel psel", K_PSEL, 0, 0);

    moves(KEY_RT, 7);
    expect_cursor("right7", 0, 7);
    act(KEY_RT);
    expect_cursor("right wrap", 0, 0);
    act(KEY_DN);
    expect_cursor("down wrap", 7, 0);
    act(KEY_UP);
    expect_cursor("up wrap", 0, 0);
    tick();
    KeyUp = 1'b1;
    repeat (5) tick();
    KeyUp = 1'b0;
    expect_cursor("up held", 1, 0);

    // White pawn e2-e4.
    moves(KEY_RT, 4);
    act(KEY_SEL);
    expect_v("sel pawn psel", K_PSEL, 0, 1);
    expect_v("sel pawn srow", K_SROW, 0, 1);
    expect_v("sel pawn scol", K_SCOL, 0, 4);
    moves(KEY_UP, 2);
    act(KEY_SEL);
    expect_sq("move1", 12, 0);
    expect_sq("move1", 28, 1);
    expect_v("move1 movedone", K_MD, 0, 1);
    expect_status("move1", 0, 1, 1, 0);
    tick();
    expect_v("move1 movedone drop", K_MD, 0, 0);

    // Black pawn d7-d5.
    moves(KEY_UP, 3);
    act(KEY_LF);
    act(KEY_SEL);
    expect_v("black sel psel", K_PSEL, 0, 1);
    moves(KEY_DN, 2);
    act(KEY_SEL);
    expect_sq("move2", 51, 0);
    expect_sq("move2", 35, 9);
    expect_status("move2", 0, 0, 2, 0);

    // White to move cannot pick a black pawn.
    moves(KEY_UP, 2);
    moves(KEY_LF, 3);
    act(KEY_SEL);
    expect_cursor("at a7", 6, 0);
    expect_v("foreign psel", K_PSEL, 0, 0);

    // Knight, then reselect bishop, then cancel.
    moves(KEY_DN, 6);
    act(KEY_RT);
    act(KEY_SEL);
    expect_v("knight psel", K_PSEL, 0, 1);
    expect_v("knight scol", K_SCOL, 0, 1);
    act(KEY_RT);
    act(KEY_SEL);
    expect_v("reselect psel", K_PSEL, 0, 1);
    expect_v("reselect srow", K_SROW, 0, 0);
    expect_v("reselect scol", K_SCOL, 0, 2);
    act(KEY_SEL);
    expect_v("cancel2 psel", K_PSEL, 0, 0);
    expect_sq("cancel2", 2, 3);
    expect_v("cancel2 count", K_MC, 0, 2);

    // Capture: e4xd5.
    moves(KEY_UP, 3);
    moves(KEY_RT, 2);
    act(KEY_SEL);
    expect_v("cap sel srow", K_SROW, 0, 3);
    act(KEY_UP);
    act(KEY_LF);
    act(KEY_SEL);
    expect_sq("capture", 28, 0);
    expect_sq("capture", 35, 1);
    expect_v("capture movedone", K_MD, 0, 1);
    expect_status("capture", 0, 1, 3, 9);

`ifdef CHESS_UNDO_EN
    act(KEY_UNDO);
    expect_sq("undo1", 28, 1);
    expect_sq("undo1", 35, 9);
    expect_v("undo1 movedone", K_MD, 0, 0);
    expect_status("undo1", 0, 0, 2, 0);
    act(KEY_UNDO);
    expect_sq("undo2", 28, 1);
    expect_sq("undo2", 35, 9);
    expect_status("undo2", 0, 0, 2, 0);
    moves(KEY_DN, 3);
`else
    act(KEY_UNDO);
    expect_sq("undo off", 28, 0);
    expect_sq("undo off", 35, 1);
    expect_status("undo off", 0, 1, 3, 9);
    moves(KEY_UP, 3);
`endif
    act(KEY_SEL);
    expect_v("pre-reset psel", K_PSEL, 0, 1);

    // Asynchronous reset in the middle of a cycle while SELECTED.
    @(posedge clock); #3;
    resetApp = 1'b1;
    expect_status("async reset", 0, 0, 0, 0);
    expect_sq("async reset", 35, 0);
    tick();
    resetApp = 1'b0;
    expect_reset("reset2");

    repeat (3) tick();
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending checks, expected 0", q.size());
      n_total++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
